// File: rtl/pu_or1k_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pu_or1k_wb_pkg
//  Description : Shared constants for the cappuccino writeback scheduler:
//                source indices and same-cycle tie-break ranking.
//  Revision    : 1.0 - initial release
// ============================================================================
package pu_or1k_wb_pkg;

    localparam int WB_NSRC    = 4;
    localparam int WB_SRC_ALU = 0;
    localparam int WB_SRC_MUL = 1;
    localparam int WB_SRC_LSU = 2;
    localparam int WB_SRC_SPR = 3;

    // Rank per source index, higher rank counts as older: LSU > MUL > SPR > ALU
    localparam int WB_PRIO_W = 2;
    localparam logic [WB_NSRC*WB_PRIO_W-1:0] WB_PRIO = {2'd1, 2'd3, 2'd2, 2'd0};

    // Bit [i*N+j] set when source i beats source j on a same-cycle accept
    function automatic logic [WB_NSRC*WB_NSRC-1:0] wb_tie_matrix();
        logic [WB_NSRC*WB_NSRC-1:0] m;
        m = '0;
        for (int i = 0; i < WB_NSRC; i++) begin
            for (int j = 0; j < WB_NSRC; j++) begin
                m[i*WB_NSRC+j] = (WB_PRIO[i*WB_PRIO_W +: WB_PRIO_W] >
                                  WB_PRIO[j*WB_PRIO_W +: WB_PRIO_W]);
            end
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pu_or1k_wb_age_matrix.sv
`default_nettype none
// ============================================================================
//  Module      : pu_or1k_wb_age_matrix
//  Description : Arrival-order tracker; grants the oldest valid entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module pu_or1k_wb_age_matrix
    import pu_or1k_wb_pkg::*;
#(
    parameter int               N         = WB_NSRC,
    parameter logic [N*N-1:0]   TIE_OLDER = wb_tie_matrix()
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_valid,
    input  logic [N-1:0] i_set,
    input  logic [N-1:0] i_clr,
    input  logic         i_flush,
    output logic [N-1:0] o_grant
);

    // r_older_q[i][j] = 1 : entry i arrived before entry j
    logic [N-1:0][N-1:0] r_older_q;
    logic [N-1:0][N-1:0] w_older_d;
    logic [N-1:0]        w_blocked;

    always_comb begin
        w_older_d = r_older_q;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (i != j) begin
                    if (i_flush) begin
                        w_older_d[i][j] = 1'b0;
                    end else if (i_set[i]) begin
                        w_older_d[i][j] = i_set[j] & TIE_OLDER[i*N+j];
                    end else if (i_set[j]) begin
                        w_older_d[i][j] = i_valid[i] & ~i_clr[i];
                    end
                end
            end
        end
    end

    // Stale bits of invalid rows are masked by i_valid, so they never block
    always_comb begin
        w_blocked = '0;
        o_grant   = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (i != j) begin
                    w_blocked[i] = w_blocked[i] | (i_valid[j] & r_older_q[j][i]);
                end
            end
            o_grant[i] = i_valid[i] & ~w_blocked[i] & ~i_flush;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_older_q <= '0;
        end else begin
            r_older_q <= w_older_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pu_or1k_wb_sched_cappuccino.sv
`default_nettype none
// ============================================================================
//  Module      : pu_or1k_wb_sched_cappuccino
//  Description : Oldest-first writeback scheduler sharing the single
//                register-file write port among ALU, MUL, LSU and SPR results.
//  Revision    : 1.0 - initial release
// ============================================================================
module pu_or1k_wb_sched_cappuccino
    import pu_or1k_wb_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_RF_ADDR_WIDTH = 5
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [WB_NSRC-1:0]                      src_valid_i,
    output logic [WB_NSRC-1:0]                      src_ready_o,
    input  logic [WB_NSRC*OPTION_OPERAND_WIDTH-1:0] src_data_i,
    input  logic [WB_NSRC*OPTION_RF_ADDR_WIDTH-1:0] src_addr_i,
    input  logic                                    flush_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0]         hazard_addr_i,
    output logic                                    hazard_o,
    output logic                                    rf_we_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0]         rf_waddr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]         rf_wdata_o,
    output logic                                    busy_o
);

    localparam int DW = OPTION_OPERAND_WIDTH;
    localparam int AW = OPTION_RF_ADDR_WIDTH;

    logic [WB_NSRC-1:0]         r_hold_v_q,    w_hold_v_d;
    logic [WB_NSRC-1:0][DW-1:0] r_hold_data_q, w_hold_data_d;
    logic [WB_NSRC-1:0][AW-1:0] r_hold_addr_q, w_hold_addr_d;
    logic                       r_rf_we_q,     w_rf_we_d;
    logic [AW-1:0]              r_rf_waddr_q,  w_rf_waddr_d;
    logic [DW-1:0]              r_rf_wdata_q,  w_rf_wdata_d;

    logic [WB_NSRC-1:0] w_grant;
    logic [WB_NSRC-1:0] w_ready;
    logic [WB_NSRC-1:0] w_accept;
    logic [AW-1:0]      w_gnt_addr;
    logic [DW-1:0]      w_gnt_data;
    logic               w_hazard;

    pu_or1k_wb_age_matrix #(
        .N (WB_NSRC)
    ) u_age (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_hold_v_q),
        .i_set   (w_accept),
        .i_clr   (w_grant),
        .i_flush (flush_i),
        .o_grant (w_grant)
    );

    // A slot granted this cycle frees up at the same edge, so it may refill
    assign w_ready  = (~r_hold_v_q | w_grant) & {WB_NSRC{~flush_i}};
    assign w_accept = src_valid_i & w_ready;

    always_comb begin
        w_hold_v_d    = flush_i ? '0 : ((r_hold_v_q & ~w_grant) | w_accept);
        w_hold_data_d = r_hold_data_q;
        w_hold_addr_d = r_hold_addr_q;
        for (int i = 0; i < WB_NSRC; i++) begin
            if (w_accept[i]) begin
                w_hold_data_d[i] = src_data_i[i*DW +: DW];
                w_hold_addr_d[i] = src_addr_i[i*AW +: AW];
            end
        end
    end

    always_comb begin
        w_gnt_addr = '0;
        w_gnt_data = '0;
        w_hazard   = 1'b0;
        for (int i = 0; i < WB_NSRC; i++) begin
            w_gnt_addr = w_gnt_addr | (r_hold_addr_q[i] & {AW{w_grant[i]}});
            w_gnt_data = w_gnt_data | (r_hold_data_q[i] & {DW{w_grant[i]}});
            w_hazard   = w_hazard | (r_hold_v_q[i] &
                                     (r_hold_addr_q[i] == hazard_addr_i) &
                                     (r_hold_addr_q[i] != '0));
        end
    end

    // r0 results retire through the grant but never raise the write enable
    always_comb begin
        w_rf_we_d    = (|w_grant) & (w_gnt_addr != '0);
        w_rf_waddr_d = (|w_grant) ? w_gnt_addr : r_rf_waddr_q;
        w_rf_wdata_d = (|w_grant) ? w_gnt_data : r_rf_wdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_v_q    <= '0;
            r_hold_data_q <= '0;
            r_hold_addr_q <= '0;
            r_rf_we_q     <= 1'b0;
            r_rf_waddr_q  <= '0;
            r_rf_wdata_q  <= '0;
        end else begin
            r_hold_v_q    <= w_hold_v_d;
            r_hold_data_q <= w_hold_data_d;
            r_hold_addr_q <= w_hold_addr_d;
            r_rf_we_q     <= w_rf_we_d;
            r_rf_waddr_q  <= w_rf_waddr_d;
            r_rf_wdata_q  <= w_rf_wdata_d;
        end
    end

    assign src_ready_o = w_ready;
    assign hazard_o    = w_hazard;
    assign busy_o      = |r_hold_v_q;
    assign rf_we_o     = r_rf_we_q;
    assign rf_waddr_o  = r_rf_waddr_q;
    assign rf_wdata_o  = r_rf_wdata_q;

endmodule
`default_nettype wire
